// File: rtl/rr_arb_pkg.sv
// Shared constants and elaboration helpers for the slot-limited round-robin arbiter.
package rr_arb_pkg;

  localparam int REQ_NUM_DEF  = 4;
  localparam int MAX_HOLD_DEF = 8;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: lowest set bit of vec searched circularly from start.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic             found
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] below;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] lowest;

  // Lower copy hides bits under start; the upper copy supplies the wrap-around.
  assign below  = ((2*N)'(1) << start) - (2*N)'(1);
  assign dbl    = {vec, vec};
  assign masked = dbl & ~below;
  assign lowest = masked & (~masked + (2*N)'(1));
  assign onehot = lowest[N-1:0] | lowest[2*N-1:N];
  assign found  = |vec;

endmodule

// File: rtl/rr_arb_slot.sv
// Round-robin arbiter with time-slice limit, owner lock and back-to-back handover.
module rr_arb_slot
  import rr_arb_pkg::*;
#(
  parameter int REQ_NUM  = REQ_NUM_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int IDX_W    = clog2(REQ_NUM),
  parameter int HOLD_W   = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REQ_NUM-1:0] req,
  input  logic               lock,
  output logic [REQ_NUM-1:0] grant,
  output logic               grant_vld,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [HOLD_W-1:0]  hold_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REQ_NUM - 1);
  localparam bit SLICE_EN = (MAX_HOLD != 0);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   after_owner;
  logic [REQ_NUM-1:0] waiters;
  logic [REQ_NUM-1:0] idle_oh;
  logic [REQ_NUM-1:0] hand_oh;
  logic               idle_found;
  logic               hand_found;
  logic               owned;
  logic               drop;
  logic               slice;
  logic               release_now;
  logic [REQ_NUM-1:0] grant_nxt;
  logic               vld_nxt;
  logic [HOLD_W-1:0]  hold_nxt;

  function automatic logic [IDX_W-1:0] oh2idx(input logic [REQ_NUM-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  assign owned       = grant_vld;
  assign waiters     = req & ~grant;
  assign after_owner = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  assign drop        = ~|(req & grant);
  assign slice       = SLICE_EN && !lock && (hold_cnt == HOLD_SAT) && (|waiters);
  assign release_now = owned && (drop || slice);

  rr_pick #(.N(REQ_NUM), .IDX_W(IDX_W)) u_pick_idle (
    .vec    (req),
    .start  (ptr),
    .onehot (idle_oh),
    .found  (idle_found)
  );

  // Handover search starts just past the outgoing owner so it becomes lowest priority.
  rr_pick #(.N(REQ_NUM), .IDX_W(IDX_W)) u_pick_hand (
    .vec    (waiters),
    .start  (after_owner),
    .onehot (hand_oh),
    .found  (hand_found)
  );

  always_comb begin
    grant_nxt = grant;
    vld_nxt   = grant_vld;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (!owned) begin
      grant_nxt = idle_oh;
      vld_nxt   = idle_found;
      hold_nxt  = '0;
    end else if (release_now) begin
      grant_nxt = hand_oh;
      vld_nxt   = hand_found;
      ptr_nxt   = after_owner;
      hold_nxt  = '0;
    end else if (hold_cnt != HOLD_SAT) begin
      hold_nxt  = hold_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_idx <= '0;
      hold_cnt  <= '0;
      ptr       <= '0;
    end else begin
      grant     <= grant_nxt;
      grant_vld <= vld_nxt;
      grant_idx <= oh2idx(grant_nxt);
      hold_cnt  <= hold_nxt;
      ptr       <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb_slot.sv
// Directed bench for rr_arb_slot (REQ_NUM=4, MAX_HOLD=4) with hand-computed expectations.
module tb_rr_arb_slot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [2:0] hold_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arb_slot #(.REQ_NUM(4), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx),
    .hold_cnt  (hold_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] g, input logic [1:0] i,
                           input logic [2:0] h);
    chk({tag, ".grant"}, 8'(grant), 8'(g));
    chk({tag, ".vld"},   8'(grant_vld), 8'(|g));
    chk({tag, ".idx"},   8'(grant_idx), 8'(i));
    chk({tag, ".hold"},  8'(hold_cnt), 8'(h));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = 4'b0000;
    lock  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state and idle with no requests
    do_reset();
    chk_state("reset", 4'b0000, 2'd0, 3'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_state($sformatf("idle%0d", c), 4'b0000, 2'd0, 3'd0);
    end

    // Single request, drop, then wrap of the pointer
    req = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_state($sformatf("src2_%0d", c), 4'b0100, 2'd2, 3'(c));
    end
    req = 4'b0000;
    tick();
    chk_state("src2_drop", 4'b0000, 2'd0, 3'd0);
    req = 4'b0101;
    tick();
    chk_state("wrap", 4'b0001, 2'd0, 3'd0);
    req = 4'b0000;
    tick();
    chk_state("wrap_drop", 4'b0000, 2'd0, 3'd0);

    // All requesting: slices of 4 cycles rotating 0,1,2,3,0 with no gap
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        chk_state($sformatf("rot%0d_%0d", k, c), 4'(1 << (k % 4)), 2'(k % 4), 3'(c));
      end
    end
    req = 4'b0000;
    tick();
    chk_state("rot_end", 4'b0000, 2'd0, 3'd0);

    // Sole requester saturates, then hands over once another source asks
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_state($sformatf("solo%0d", c), 4'b0010, 2'd1, (c < 3) ? 3'(c) : 3'd3);
    end
    req = 4'b1010;
    tick();
    chk_state("solo_hand", 4'b1000, 2'd3, 3'd0);

    // Lock holds the owner past its slice; unlocking releases on the next edge
    do_reset();
    lock = 1'b1;
    req  = 4'b0011;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk_state($sformatf("lock%0d", c), 4'b0001, 2'd0, (c < 3) ? 3'(c) : 3'd3);
    end
    lock = 1'b0;
    tick();
    chk_state("unlock", 4'b0010, 2'd1, 3'd0);

    // Drop of owner 1 hands straight to source 3
    req = 4'b1000;
    tick();
    chk_state("to_src3", 4'b1000, 2'd3, 3'd0);

    // Asynchronous reset mid-grant, then pointer back at 0
    rst_n = 1'b0;
    #2;
    chk_state("async_rst", 4'b0000, 2'd0, 3'd0);
    #3;
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    chk_state("post_rst", 4'b0001, 2'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arb_slot.md
Name: rr_arb_slot

Overview:
Parametrised round-robin arbiter that replaces the counter-scanning simple RR arbiter. It grants one of REQ_NUM requesters using a rotating-priority pointer, so an idle requester never costs scan cycles. It enforces a configurable maximum hold time (time slice), supports an owner lock, and hands the grant directly to the next requester without an idle cycle. It sits in front of shared resources (bus, memory port) wherever several sources contend.

Parameters:
REQ_NUM, 4, number of requesting sources (>=2)
MAX_HOLD, 8, maximum consecutive grant cycles per owner when others wait; 0 = no limit
IDX_W, clog2(REQ_NUM), width of grant index
HOLD_W, clog2(MAX_HOLD+1) (min 1), width of hold counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  REQ_NUM  per-source request, level, held while access is wanted
lock  input  1  when high, the current owner is not pre-empted by the slice limit
grant  output  REQ_NUM  registered one-hot grant (all-zero = no owner)
grant_vld  output  1  registered, equals |grant
grant_idx  output  IDX_W  registered binary index of owner; 0 when grant_vld=0
hold_cnt  output  HOLD_W  cycles the current owner has held grant, minus 1; 0 when idle

Behaviour:
- Reset (async, rst_n=0): grant=0, grant_vld=0, grant_idx=0, hold_cnt=0, internal pointer ptr=0. Outputs are valid the first edge after release.
- pick(vec, start): lowest index i with vec[i]=1, searched circularly start, start+1, ..., REQ_NUM-1, 0, ...; returns none if vec=0.
- IDLE (grant=0), each edge: if |req, grant <= onehot(pick(req, ptr)), hold_cnt <= 0; else stay idle. Latency req->grant = 1 cycle.
- OWNED (owner o), release condition evaluated each edge:
  - drop: req[o]=0, or
  - slice: MAX_HOLD!=0 and lock=0 and hold_cnt==MAX_HOLD-1 and |(req & ~grant).
- On release: grant <= onehot(pick(req & ~grant, o+1 mod REQ_NUM)) (zero if no other request), ptr <= o+1 mod REQ_NUM, hold_cnt <= 0. Handover is back-to-back: the new owner is granted on the same edge the old grant drops.
- No release: grant is held. hold_cnt <= hold_cnt+1, saturating at MAX_HOLD-1 (at 0 if MAX_HOLD=0 is unused; the counter then saturates at all-ones).
- Sole requester: it is never pre-empted. hold_cnt saturates. When a second request appears while hold_cnt is saturated at MAX_HOLD-1 and lock=0, the grant hands over on the next edge.
- lock asserted while hold_cnt is saturated: the grant is held indefinitely. Deasserting lock with waiters pending causes release at the next edge.
- A requester whose req drops while not granted is simply skipped. Its req is not remembered.
- Simultaneous drop and slice: treated as a single release. Same result.
- ptr only advances on release, so a source that was granted is lowest priority in the next arbitration.
- Reset mid-grant: grant clears immediately (asynchronously). ptr returns to 0.
- Grant is always one-hot or zero. It is never asserted for a source whose req was 0 at the deciding edge.

Decomposition:
- Package rr_arb_pkg: clog2 function, default REQ_NUM/MAX_HOLD constants.
- Sub-module rr_pick: combinational rotating-priority encoder (vec, start -> onehot, found), implemented with a double-width mask. Instantiated twice: once for the idle pick and once for the handover pick.
- The top level holds ptr, grant and hold_cnt registers and the release logic.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> grant=0, grant_vld=0, grant_idx=0, hold_cnt=0 throughout.
- After reset, req=4'b0100 at cycle 0 -> cycle 1 grant=4'b0100, grant_idx=2. req drops at cycle 3 -> cycle 4 grant=0; ptr=3, so the next req=4'b0101 grants source 0 (wrap).
- MAX_HOLD=4, req=4'b1111 held constant, lock=0 -> grants rotate 0,1,2,3,0, each held exactly 4 cycles, no idle cycle between owners.
- MAX_HOLD=4, source 1 sole requester for 10 cycles, then req[3] rises -> grant stays 4'b0010 with hold_cnt saturated at 3; grant=4'b1000 one edge after req[3] rises.
- lock=1 while source 0 is owner with req=4'b0011 for 12 cycles -> grant stays 4'b0001. lock falls -> next edge grant=4'b0010.
- rst_n pulsed low for half a cycle while grant=4'b1000 -> grant=0 immediately. After release, req=4'b1001 grants source 0 (ptr=0).
